// File: rtl/mem_access_stage.sv
// MEM-stage data-memory unit: byte/half/word loads and stores against a word memory.
// Optional macro DMEM_ALIGN_CHECK_EN enables alignment-fault suppression and sticky status.
module mem_access_stage #(
    parameter int ADDR_W = 6
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MEM_MemRd,
    input  logic        MEM_MemWr,
    input  logic [1:0]  MEM_Size,
    input  logic        MEM_Unsigned,
    input  logic [31:0] MEM_Result,
    input  logic [31:0] MEM_StoreData,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_RegWr,
    input  logic [4:0]  MEM_Rw,
    output logic [31:0] MEM_MemOut,
    output logic        MEM_MemtoReg_o,
    output logic        MEM_RegWr_o,
    output logic [4:0]  MEM_Rw_o,
    output logic [31:0] MEM_Result_o,
    output logic        AlignErr,
    output logic [31:0] ErrAddr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic              fault;
    logic [31:0]       rd_word;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [31:0]       load_data;
    logic [31:0]       wr_word_d;
    logic              wr_en;

    assign word_idx = MEM_Result[ADDR_W+1:2];
    assign lane     = MEM_Result[1:0];
    assign rd_word  = mem_q[word_idx];

`ifdef DMEM_ALIGN_CHECK_EN
    logic        misaligned;
    logic        align_err_q, align_err_d;
    logic [31:0] err_addr_q, err_addr_d;

    assign misaligned = ((MEM_Size == 2'b01) && lane[0]) || (MEM_Size[1] && (lane != 2'b00));
    assign fault      = (MEM_MemRd || MEM_MemWr) && misaligned;

    // ErrAddr records only the first fault; AlignErr is sticky until reset.
    always_comb begin
        align_err_d = align_err_q;
        err_addr_d  = err_addr_q;
        if (fault) begin
            align_err_d = 1'b1;
            if (!align_err_q) err_addr_d = MEM_Result;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            align_err_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            align_err_q <= align_err_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign AlignErr = align_err_q;
    assign ErrAddr  = err_addr_q;
`else
    assign fault    = 1'b0;
    assign AlignErr = 1'b0;
    assign ErrAddr  = '0;
`endif

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel_byte  = rd_word[{lane, 3'b000} +: 8];
        sel_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        case (MEM_Size)
            2'b00:   load_data = {{24{~MEM_Unsigned & sel_byte[7]}}, sel_byte};
            2'b01:   load_data = {{16{~MEM_Unsigned & sel_half[15]}}, sel_half};
            default: load_data = rd_word;
        endcase
        if (!MEM_MemRd || fault) load_data = '0;
    end

    // Merge the store lanes into the current word; unaddressed lanes keep old contents.
    always_comb begin
        wr_word_d = rd_word;
        case (MEM_Size)
            2'b00: wr_word_d[{lane, 3'b000} +: 8] = MEM_StoreData[7:0];
            2'b01: begin
                if (lane[1]) wr_word_d[31:16] = MEM_StoreData[15:0];
                else         wr_word_d[15:0]  = MEM_StoreData[15:0];
            end
            default: wr_word_d = MEM_StoreData;
        endcase
    end

    assign wr_en = MEM_MemWr && !fault;

    // NOTE: the memory is cleared by reset, so it is a register array rather than a RAM macro;
    // state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[word_idx] <= wr_word_d;
        end
    end

    assign MEM_MemOut     = load_data;
    assign MEM_MemtoReg_o = MEM_MemtoReg;
    assign MEM_RegWr_o    = MEM_RegWr && !(fault && MEM_MemRd);
    assign MEM_Rw_o       = MEM_Rw;
    assign MEM_Result_o   = MEM_Result;

endmodule
